// File: rtl/microwave_timer.sv
// Cook-time entry and 1 Hz countdown for the microwave controller.
// Keypad digits shift in as M:ST; door interlock and stop/clear pause or abort cooking.
module microwave_timer #(
  parameter int CLKS_PER_SEC = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop_clear,
  input  logic       door_closed,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min,
  output logic       mag_on,
  output logic       done
);

  localparam int PW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;

  typedef enum logic [1:0] {SETUP, COOK, PAUSED, DONE} state_t;

  state_t        state;
  logic [PW-1:0] prescaler;
  logic          tick;
  logic          time_nz;
  logic [11:0]   dec_next;

  // One-second countdown step; a zero ones digit borrows from tens, zero tens from minutes.
  function automatic logic [11:0] dec_time(input logic [3:0] m, input logic [3:0] t,
                                           input logic [3:0] o);
    logic [11:0] r;
    r = {m, t, o};
    if (o != 4'd0) begin
      r[3:0] = o - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (t != 4'd0) begin
        r[7:4] = t - 4'd1;
      end else begin
        r[7:4]  = 4'd5;
        r[11:8] = m - 4'd1;
      end
    end
    return r;
  endfunction

  assign tick     = (prescaler == PW'(CLKS_PER_SEC - 1));
  assign time_nz  = ({min, sec_tens, sec_ones} != 12'd0);
  assign dec_next = dec_time(min, sec_tens, sec_ones);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SETUP;
      prescaler <= '0;
      min       <= 4'd0;
      sec_tens  <= 4'd0;
      sec_ones  <= 4'd0;
      mag_on    <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        SETUP: begin
          if (stop_clear) begin
            {min, sec_tens, sec_ones} <= 12'd0;
          end else if (start && door_closed && time_nz) begin
            state     <= COOK;
            prescaler <= '0;
            mag_on    <= 1'b1;
          end else if (key_valid && !start && key_digit <= 4'd9) begin
            min      <= sec_tens;
            sec_tens <= sec_ones;
            sec_ones <= key_digit;
          end
        end
        COOK: begin
          // A pause request wins over a tick landing in the same cycle.
          if (stop_clear || !door_closed) begin
            state  <= PAUSED;
            mag_on <= 1'b0;
          end else if (tick) begin
            prescaler                 <= '0;
            {min, sec_tens, sec_ones} <= dec_next;
            if (dec_next == 12'd0) begin
              state  <= DONE;
              mag_on <= 1'b0;
              done   <= 1'b1;
            end
          end else begin
            prescaler <= prescaler + 1'b1;
          end
        end
        PAUSED: begin
          if (stop_clear) begin
            state                     <= SETUP;
            {min, sec_tens, sec_ones} <= 12'd0;
          end else if (start && door_closed) begin
            state     <= COOK;
            prescaler <= '0;
            mag_on    <= 1'b1;
          end
        end
        DONE: begin
          if (stop_clear || !door_closed || key_valid) begin
            state <= SETUP;
            done  <= 1'b0;
          end
        end
        default: begin
          state  <= SETUP;
          mag_on <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_microwave_timer.sv
// Bench for microwave_timer: directed scenarios with literal expectations plus
// randomized stimulus checked every cycle against a time-value reference model.
module tb_microwave_timer;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       start = 1'b0;
  logic       stop_clear = 1'b0;
  logic       door_closed = 1'b1;
  logic [3:0] sec_ones, sec_tens, min;
  logic       mag_on, done;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  microwave_timer #(.CLKS_PER_SEC(C)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .stop_clear(stop_clear), .door_closed(door_closed),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min(min),
    .mag_on(mag_on), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: time held as a 3-digit decimal number M*100 + ST.
  typedef enum {M_SETUP, M_COOK, M_PAUSED, M_DONE} mode_t;
  mode_t m_mode = M_SETUP;
  int    m_tv   = 0;
  int    m_cyc  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_SETUP; m_tv = 0; m_cyc = 0;
    end else begin
      case (m_mode)
        M_SETUP:
          if (stop_clear) m_tv = 0;
          else if (start && door_closed && m_tv != 0) begin m_mode = M_COOK; m_cyc = 0; end
          else if (key_valid && !start && key_digit <= 9) m_tv = (m_tv % 100) * 10 + key_digit;
        M_COOK:
          if (stop_clear || !door_closed) m_mode = M_PAUSED;
          else begin
            m_cyc++;
            if (m_cyc == C) begin
              m_cyc = 0;
              m_tv  = m_tv - 1;
              if (m_tv % 100 == 99) m_tv -= 40;
              if (m_tv == 0) m_mode = M_DONE;
            end
          end
        M_PAUSED:
          if (stop_clear) begin m_mode = M_SETUP; m_tv = 0; end
          else if (start && door_closed) begin m_mode = M_COOK; m_cyc = 0; end
        M_DONE:
          if (stop_clear || !door_closed || key_valid) m_mode = M_SETUP;
        default: m_mode = M_SETUP;
      endcase
    end
  end

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_digits", {min, sec_tens, sec_ones},
          {4'(m_tv / 100), 4'((m_tv / 10) % 10), 4'(m_tv % 10)});
      chk("model_mag_on", {11'd0, mag_on}, {11'd0, m_mode == M_COOK});
      chk("model_done",   {11'd0, done},   {11'd0, m_mode == M_DONE});
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(input logic [3:0] d);
    key_digit = d; key_valid = 1'b1; step(); key_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic do_stop();
    stop_clear = 1'b1; step(); stop_clear = 1'b0;
  endtask

  task automatic lit(input string name, input logic [11:0] dig, input logic m, input logic d);
    chk({name, "_digits"}, {min, sec_tens, sec_ones}, dig);
    chk({name, "_mag"}, {11'd0, mag_on}, {11'd0, m});
    chk({name, "_done"}, {11'd0, done}, {11'd0, d});
  endtask

  initial begin
    #1 rst_n = 1'b0;
    steps(2);
    lit("reset", 12'h000, 1'b0, 1'b0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    step();

    // Entry 1:30 and countdown
    press(4'd1); press(4'd3); press(4'd0);
    lit("entry130", 12'h130, 1'b0, 1'b0);
    do_start();
    lit("start130", 12'h130, 1'b1, 1'b0);
    steps(C - 1);
    lit("pre_tick", 12'h130, 1'b1, 1'b0);
    step();
    lit("tick1", 12'h129, 1'b1, 1'b0);
    steps(30 * C);
    lit("tick31", 12'h059, 1'b1, 1'b0);
    do_stop(); do_stop();
    lit("cleared", 12'h000, 1'b0, 1'b0);

    // 0:90 to the end
    press(4'd9); press(4'd0);
    do_start();
    steps(90 * C - 1);
    lit("last_sec", 12'h001, 1'b1, 1'b0);
    step();
    lit("done", 12'h000, 1'b0, 1'b1);
    do_stop();
    lit("after_done", 12'h000, 1'b0, 1'b0);

    // Door opened mid-second, then resumed
    press(4'd5);
    do_start();
    steps(2);
    door_closed = 1'b0; step();
    lit("door_pause", 12'h005, 1'b0, 1'b0);
    door_closed = 1'b1; steps(3);
    lit("paused_hold", 12'h005, 1'b0, 1'b0);
    do_start();
    steps(C - 1);
    lit("resume_pre", 12'h005, 1'b1, 1'b0);
    step();
    lit("resume_tick", 12'h004, 1'b1, 1'b0);
    do_stop(); do_stop();

    // Ignored starts and out-of-range digit
    do_start();
    lit("start_zero", 12'h000, 1'b0, 1'b0);
    press(4'd7);
    door_closed = 1'b0; do_start();
    lit("start_open", 12'h007, 1'b0, 1'b0);
    door_closed = 1'b1;
    press(4'd12);
    lit("digit12", 12'h007, 1'b0, 1'b0);
    do_stop();

    // stop_clear on the tick cycle at 0:01
    press(4'd2);
    do_start();
    steps(2 * C - 1);
    lit("at_001", 12'h001, 1'b1, 1'b0);
    do_stop();
    lit("stop_on_tick", 12'h001, 1'b0, 1'b0);
    do_stop();
    lit("stop_setup", 12'h000, 1'b0, 1'b0);

    // Asynchronous reset mid-cook at 2:15
    press(4'd2); press(4'd1); press(4'd5);
    do_start();
    steps(2);
    #2 rst_n = 1'b0;
    #1 lit("async_rst", 12'h000, 1'b0, 1'b0);
    #3 rst_n = 1'b1;
    step();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 19) == 0) door_closed = ~door_closed;
      stop_clear = (r < 3);
      start      = (r >= 3 && r < 12);
      key_valid  = (r >= 12 && r < 40 && door_closed);
      key_digit  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15))
                                               : 4'($urandom_range(0, 3));
      rst_n      = ($urandom_range(0, 499) != 0);
      step();
    end
    stop_clear = 1'b0; start = 1'b0; key_valid = 1'b0; rst_n = 1'b1;
    steps(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
